mem_access: RTL and testbench

Memory-access stage of the cqu_mips five-stage pipeline, between execute and `write_back`. Issues loads and stores to the data memory over an SRAM-like request/response interface, aligns and extends load data, builds store byte strobes, and registers the result (ALU value or load data) plus destination, PC and instruction into the write-back stage. Holds the upstream pipeline with `mem_stall` while a memory transaction is outstanding.

---
 rtl/mem_access_if.sv | 61 ++++++
 rtl/mem_access.sv | 215 +++++++++++++++++++++
 tb/tb_mem_access.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Pipeline-side and data-memory-side signals of the cqu_mips memory-access stage.
// MEM_ADDR_EXC_EN adds the misaligned-address exception outputs.
interface mem_access_if;
    logic        stall;
    logic        in_valid;
    logic [3:0]  mem_op;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  write_addr_in;
    logic        reg_write_in;
    logic [31:0] pc_in;
    logic [31:0] inst_in;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        mem_stall;
    logic        wb_valid;
    logic [4:0]  write_addr_out;
    logic        reg_write_out;
    logic [31:0] write_data_out;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
`ifdef MEM_ADDR_EXC_EN
    logic        addr_exc;
    logic [31:0] bad_vaddr;
`endif

    // The stage itself: issues memory requests and drives write-back.
    modport master (
        input  stall, in_valid, mem_op, alu_result, store_data,
        input  write_addr_in, reg_write_in, pc_in, inst_in,
        input  data_addr_ok, data_data_ok, data_rdata,
`ifdef MEM_ADDR_EXC_EN
        output addr_exc, bad_vaddr,
`endif
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output mem_stall, wb_valid, write_addr_out, reg_write_out,
        output write_data_out, pc_out, inst_out
    );

    // Surrounding pipeline and data memory.
    modport slave (
        output stall, in_valid, mem_op, alu_result, store_data,
        output write_addr_in, reg_write_in, pc_in, inst_in,
        output data_addr_ok, data_data_ok, data_rdata,
`ifdef MEM_ADDR_EXC_EN
        input  addr_exc, bad_vaddr,
`endif
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  mem_stall, wb_valid, write_addr_out, reg_write_out,
        input  write_data_out, pc_out, inst_out
    );
endinterface

// File: rtl/mem_access.sv
// cqu_mips memory-access stage: SRAM-like load/store issue, load alignment, write-back register.
// Optional MEM_ADDR_EXC_EN: misaligned half/word accesses raise addr_exc instead of a request.
module mem_access (
    input logic          i_clk,
    input logic          i_rst,
    mem_access_if.master bus
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_HOLD} state_t;

    state_t      r_state;
    logic        r_data_req, r_data_wr;
    logic [1:0]  r_data_size;
    logic [31:0] r_data_addr, r_data_wdata;
    logic [3:0]  r_data_wstrb;
    logic        r_wb_valid, r_reg_write;
    logic [4:0]  r_write_addr;
    logic [31:0] r_write_data, r_pc, r_inst;
    logic        r_hold_rw;
    logic [4:0]  r_hold_waddr;
    logic [31:0] r_hold_data, r_hold_pc, r_hold_inst;
`ifdef MEM_ADDR_EXC_EN
    logic        r_addr_exc;
    logic [31:0] r_bad_vaddr;
`endif

    logic        w_is_load, w_is_store, w_is_mem, w_misalign, w_mem_go, w_rw;
    logic [1:0]  w_size;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata, w_load_data, w_result;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Opcode decode and request field construction.
    always_comb begin
        w_is_load  = (bus.mem_op >= OP_LB) && (bus.mem_op <= OP_LW);
        w_is_store = (bus.mem_op >= OP_SB) && (bus.mem_op <= OP_SW);
        w_is_mem   = w_is_load || w_is_store;
        w_size     = 2'd2;
        w_wstrb    = 4'b0000;
        w_wdata    = bus.store_data;
        w_misalign = 1'b0;
        case (bus.mem_op)
            OP_LB, OP_LBU: w_size = 2'd0;
            OP_LH, OP_LHU: w_size = 2'd1;
            OP_SB: begin
                w_size  = 2'd0;
                w_wstrb = 4'(4'b0001 << bus.alu_result[1:0]);
                w_wdata = {4{bus.store_data[7:0]}};
            end
            OP_SH: begin
                w_size  = 2'd1;
                w_wstrb = bus.alu_result[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.store_data[15:0]}};
            end
            OP_SW: w_wstrb = 4'b1111;
            default: ;
        endcase
`ifdef MEM_ADDR_EXC_EN
        w_misalign = ((w_size == 2'd1) && bus.alu_result[0]) ||
                     ((w_size == 2'd2) && w_is_mem && (bus.alu_result[1:0] != 2'b00));
`endif
        w_mem_go = bus.in_valid && w_is_mem && !w_misalign;
        w_rw     = w_is_load && bus.reg_write_in;
    end

    // Load data alignment and extension.
    always_comb begin
        w_byte = 8'(bus.data_rdata >> {bus.alu_result[1:0], 3'b000});
        w_half = bus.alu_result[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
        case (bus.mem_op)
            OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_data = {24'h0, w_byte};
            OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load_data = {16'h0, w_half};
            default: w_load_data = bus.data_rdata;
        endcase
        w_result = w_is_load ? w_load_data : bus.alu_result;
    end

    // Upstream hold: data_ok in RESP releases it so execute can advance on that edge.
    assign bus.mem_stall = ((r_state == S_IDLE) && w_mem_go) || (r_state == S_REQ) ||
                           ((r_state == S_RESP) && !bus.data_data_ok) || (r_state == S_HOLD);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_data_req   <= 1'b0;
            r_data_wr    <= 1'b0;
            r_data_size  <= 2'd0;
            r_data_addr  <= 32'h0;
            r_data_wstrb <= 4'h0;
            r_data_wdata <= 32'h0;
            r_wb_valid   <= 1'b0;
            r_reg_write  <= 1'b0;
            r_write_addr <= 5'd0;
            r_write_data <= 32'h0;
            r_pc         <= 32'h0;
            r_inst       <= 32'h0;
            r_hold_rw    <= 1'b0;
            r_hold_waddr <= 5'd0;
            r_hold_data  <= 32'h0;
            r_hold_pc    <= 32'h0;
            r_hold_inst  <= 32'h0;
`ifdef MEM_ADDR_EXC_EN
            r_addr_exc   <= 1'b0;
            r_bad_vaddr  <= 32'h0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (!bus.stall) begin
                    if (bus.in_valid && !w_is_mem) begin
                        r_wb_valid   <= 1'b1;
                        r_write_data <= bus.alu_result;
                        r_reg_write  <= bus.reg_write_in;
                        r_write_addr <= bus.write_addr_in;
                        r_pc         <= bus.pc_in;
                        r_inst       <= bus.inst_in;
`ifdef MEM_ADDR_EXC_EN
                        r_addr_exc   <= 1'b0;
                    end else if (bus.in_valid && w_misalign) begin
                        r_wb_valid   <= 1'b1;
                        r_write_data <= bus.alu_result;
                        r_reg_write  <= 1'b0;
                        r_write_addr <= bus.write_addr_in;
                        r_pc         <= bus.pc_in;
                        r_inst       <= bus.inst_in;
                        r_addr_exc   <= 1'b1;
                        r_bad_vaddr  <= bus.alu_result;
`endif
                    end else if (w_mem_go) begin
                        r_state      <= S_REQ;
                        r_wb_valid   <= 1'b0;
                        r_data_req   <= 1'b1;
                        r_data_wr    <= w_is_store;
                        r_data_size  <= w_size;
                        r_data_addr  <= bus.alu_result;
                        r_data_wstrb <= w_wstrb;
                        r_data_wdata <= w_wdata;
                    end else begin
                        r_wb_valid   <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (bus.data_addr_ok) begin
                        r_data_req <= 1'b0;
                        r_state    <= S_RESP;
                    end
                    if (!bus.stall) r_wb_valid <= 1'b0;
                end
                S_RESP: begin
                    if (bus.data_data_ok && !bus.stall) begin
                        r_state      <= S_IDLE;
                        r_wb_valid   <= 1'b1;
                        r_write_data <= w_result;
                        r_reg_write  <= w_rw;
                        r_write_addr <= bus.write_addr_in;
                        r_pc         <= bus.pc_in;
                        r_inst       <= bus.inst_in;
`ifdef MEM_ADDR_EXC_EN
                        r_addr_exc   <= 1'b0;
`endif
                    end else if (bus.data_data_ok) begin
                        r_state      <= S_HOLD;
                        r_hold_data  <= w_result;
                        r_hold_rw    <= w_rw;
                        r_hold_waddr <= bus.write_addr_in;
                        r_hold_pc    <= bus.pc_in;
                        r_hold_inst  <= bus.inst_in;
                    end else if (!bus.stall) begin
                        r_wb_valid   <= 1'b0;
                    end
                end
                S_HOLD: if (!bus.stall) begin
                    r_state      <= S_IDLE;
                    r_wb_valid   <= 1'b1;
                    r_write_data <= r_hold_data;
                    r_reg_write  <= r_hold_rw;
                    r_write_addr <= r_hold_waddr;
                    r_pc         <= r_hold_pc;
                    r_inst       <= r_hold_inst;
`ifdef MEM_ADDR_EXC_EN
                    r_addr_exc   <= 1'b0;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.data_req       = r_data_req;
    assign bus.data_wr        = r_data_wr;
    assign bus.data_size      = r_data_size;
    assign bus.data_addr      = r_data_addr;
    assign bus.data_wstrb     = r_data_wstrb;
    assign bus.data_wdata     = r_data_wdata;
    assign bus.wb_valid       = r_wb_valid;
    assign bus.write_addr_out = r_write_addr;
    assign bus.reg_write_out  = r_reg_write;
    assign bus.write_data_out = r_write_data;
    assign bus.pc_out         = r_pc;
    assign bus.inst_out       = r_inst;
`ifdef MEM_ADDR_EXC_EN
    assign bus.addr_exc       = r_addr_exc;
    assign bus.bad_vaddr      = r_bad_vaddr;
`endif
endmodule

// File: tb/tb_mem_access.sv
// Directed, table-driven bench for mem_access: load/store vectors plus stall, reset
// and (with MEM_ADDR_EXC_EN) misaligned-exception sequences.
module tb_mem_access;
    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    mem_access_if bus ();

    mem_access u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic [1:0]  size;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        wr;
        logic [31:0] res;
        logic        rw;
        logic        chk_res;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                                input logic [31:0] rdata, input logic [1:0] size, input logic [3:0] strb,
                                input logic [31:0] wdata, input logic wr, input logic [31:0] res,
                                input logic rw, input logic chk_res);
        vec_t v;
        v.op = op; v.addr = addr; v.sd = sd; v.rdata = rdata; v.size = size; v.strb = strb;
        v.wdata = wdata; v.wr = wr; v.res = res; v.rw = rw; v.chk_res = chk_res;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'b0; bus.mem_op = 4'd0; bus.stall = 1'b0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    endtask

    // Full memory transaction; addr_ok arrives after d extra REQ cycles.
    task automatic run_mem(input vec_t v, input int d);
        int stall_cnt;
        int req_cnt;
        stall_cnt = 0;
        req_cnt   = 0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.mem_op = v.op; bus.alu_result = v.addr; bus.store_data = v.sd;
        bus.write_addr_in = 5'd7; bus.reg_write_in = 1'b1;
        bus.pc_in = 32'h0040_0000 + v.addr; bus.inst_in = {28'h8C0_0000, v.op};
        #1 if (bus.mem_stall) stall_cnt++;
        for (int k = 0; k <= d; k++) begin
            @(negedge clk);
            if (bus.data_req) req_cnt++;
            chk("req_addr", bus.data_addr, v.addr);
            chk("req_strb", 32'(bus.data_wstrb), 32'(v.strb));
            chk("req_wdata_size_wr", {bus.data_wdata[29:0], bus.data_size} ^ 32'(bus.data_wr),
                {v.wdata[29:0], v.size} ^ 32'(v.wr));
            bus.data_addr_ok = (k == d);
            #1 if (bus.mem_stall) stall_cnt++;
        end
        @(negedge clk);
        bus.data_addr_ok = 1'b0;
        chk("req_drop", 32'(bus.data_req), 32'd0);
        bus.data_rdata = v.rdata; bus.data_data_ok = 1'b1;
        #1 if (bus.mem_stall) stall_cnt++;
        @(negedge clk);
        bus.data_data_ok = 1'b0; bus.in_valid = 1'b0; bus.mem_op = 4'd0;
        chk("wb_valid", 32'(bus.wb_valid), 32'd1);
        if (v.chk_res) chk("load_data", bus.write_data_out, v.res);
        chk("reg_write", 32'(bus.reg_write_out), 32'(v.rw));
        chk("wb_addr_pc", {bus.write_addr_out, bus.pc_out[26:0]}, {5'd7, 27'(32'h0040_0000 + v.addr)});
        chk("stall_cycles", 32'(stall_cnt), 32'(d + 2));
        chk("req_cycles", 32'(req_cnt), 32'(d + 1));
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1;
        drive_idle();
        bus.alu_result = 32'h0; bus.store_data = 32'h0; bus.write_addr_in = 5'd0;
        bus.reg_write_in = 1'b0; bus.pc_in = 32'h0; bus.inst_in = 32'h0; bus.data_rdata = 32'h0;

        //        op     addr          sd            rdata         sz    strb     wdata         wr    res           rw    chk
        vecs.push_back(mk(4'd1, 32'h103, 32'h0,         32'h80AA_BBCC, 2'd0, 4'b0000, 32'h0,         1'b0, 32'hFFFF_FF80, 1'b1, 1'b1));
        vecs.push_back(mk(4'd2, 32'h103, 32'h0,         32'h80AA_BBCC, 2'd0, 4'b0000, 32'h0,         1'b0, 32'h0000_0080, 1'b1, 1'b1));
        vecs.push_back(mk(4'd1, 32'h101, 32'h0,         32'h1122_7F33, 2'd0, 4'b0000, 32'h0,         1'b0, 32'h0000_007F, 1'b1, 1'b1));
        vecs.push_back(mk(4'd3, 32'h102, 32'h0,         32'h80AA_BBCC, 2'd1, 4'b0000, 32'h0,         1'b0, 32'hFFFF_80AA, 1'b1, 1'b1));
        vecs.push_back(mk(4'd3, 32'h100, 32'h0,         32'h1234_F00D, 2'd1, 4'b0000, 32'h0,         1'b0, 32'hFFFF_F00D, 1'b1, 1'b1));
        vecs.push_back(mk(4'd4, 32'h100, 32'h0,         32'h1234_F00D, 2'd1, 4'b0000, 32'h0,         1'b0, 32'h0000_F00D, 1'b1, 1'b1));
        vecs.push_back(mk(4'd5, 32'h104, 32'h0,         32'hCAFE_BABE, 2'd2, 4'b0000, 32'h0,         1'b0, 32'hCAFE_BABE, 1'b1, 1'b1));
        vecs.push_back(mk(4'd6, 32'h201, 32'h1234_56A5, 32'h0,         2'd0, 4'b0010, 32'hA5A5_A5A5, 1'b1, 32'h0,         1'b0, 1'b0));
        vecs.push_back(mk(4'd6, 32'h203, 32'h0000_003C, 32'h0,         2'd0, 4'b1000, 32'h3C3C_3C3C, 1'b1, 32'h0,         1'b0, 1'b0));
        vecs.push_back(mk(4'd7, 32'h202, 32'hDEAD_BEEF, 32'h0,         2'd1, 4'b1100, 32'hBEEF_BEEF, 1'b1, 32'h0,         1'b0, 1'b0));
        vecs.push_back(mk(4'd7, 32'h200, 32'hDEAD_BEEF, 32'h0,         2'd1, 4'b0011, 32'hBEEF_BEEF, 1'b1, 32'h0,         1'b0, 1'b0));
        vecs.push_back(mk(4'd8, 32'h204, 32'h0102_0304, 32'h0,         2'd2, 4'b1111, 32'h0102_0304, 1'b1, 32'h0,         1'b0, 1'b0));
`ifndef MEM_ADDR_EXC_EN
        // Without the check, halfword uses addr[1] only and ignores addr[0].
        vecs.push_back(mk(4'd4, 32'h103, 32'h0,         32'hA55A_0001, 2'd1, 4'b0000, 32'h0,         1'b0, 32'h0000_A55A, 1'b1, 1'b1));
`endif

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_data_req", 32'(bus.data_req), 32'd0);
        chk("rst_wdata_out", bus.write_data_out, 32'h0);
        chk("rst_mem_stall", 32'(bus.mem_stall), 32'd0);

        // Non-memory op: one-cycle latency, never stalls.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.mem_op = 4'd0; bus.alu_result = 32'h1234_5678;
        bus.write_addr_in = 5'd5; bus.reg_write_in = 1'b1; bus.pc_in = 32'h0040_0010; bus.inst_in = 32'h0022_2820;
        #1 chk("alu_no_stall", 32'(bus.mem_stall), 32'd0);
        @(negedge clk);
        chk("alu_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("alu_data", bus.write_data_out, 32'h1234_5678);
        chk("alu_waddr", 32'(bus.write_addr_out), 32'd5);
        chk("alu_inst", bus.inst_out, 32'h0022_2820);
        bus.mem_op = 4'd12; bus.alu_result = 32'h0BAD_F00D; bus.reg_write_in = 1'b0;
        #1 chk("op12_no_stall", 32'(bus.mem_stall), 32'd0);
        @(negedge clk);
        chk("op12_data", bus.write_data_out, 32'h0BAD_F00D);
        chk("op12_rw", 32'(bus.reg_write_out), 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bubble_clears_valid", 32'(bus.wb_valid), 32'd0);

        for (int i = 0; i < vecs.size(); i++) run_mem(vecs[i], i % 3);
        run_mem(mk(4'd5, 32'h108, 32'h0, 32'h1357_9BDF, 2'd2, 4'b0, 32'h0, 1'b0, 32'h1357_9BDF, 1'b1, 1'b1), 4);

        // Stall in IDLE: no request may start and outputs hold.
        @(negedge clk);
        bus.stall = 1'b1; bus.in_valid = 1'b1; bus.mem_op = 4'd5; bus.alu_result = 32'h10C;
        @(negedge clk);
        chk("idle_stall_noreq", 32'(bus.data_req), 32'd0);
        chk("idle_stall_hold", bus.write_data_out, 32'h1357_9BDF);

        // Downstream stall when data_ok arrives: HOLD, then release.
        bus.stall = 1'b0; bus.alu_result = 32'h108; bus.write_addr_in = 5'd9;
        @(negedge clk);
        chk("hold_req", 32'(bus.data_req), 32'd1);
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        bus.data_addr_ok = 1'b0;
        bus.data_rdata = 32'h55AA_1234; bus.data_data_ok = 1'b1; bus.stall = 1'b1;
        #1 chk("hold_dataok_stall_low", 32'(bus.mem_stall), 32'd0);
        @(negedge clk);
        bus.data_data_ok = 1'b0; bus.in_valid = 1'b0; bus.data_rdata = 32'h0;
        #1 chk("hold_mem_stall", 32'(bus.mem_stall), 32'd1);
        chk("hold_out_frozen", bus.write_data_out, 32'h1357_9BDF);
        @(negedge clk);
        chk("hold_still", 32'(bus.mem_stall), 32'd1);
        bus.stall = 1'b0;
        @(negedge clk);
        chk("hold_release_valid", 32'(bus.wb_valid), 32'd1);
        chk("hold_release_data", bus.write_data_out, 32'h55AA_1234);
        chk("hold_release_waddr", 32'(bus.write_addr_out), 32'd9);
        #1 chk("hold_release_stall", 32'(bus.mem_stall), 32'd0);

        // Reset while in RESP; the late data_ok must be ignored.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.mem_op = 4'd5; bus.alu_result = 32'h110;
        @(negedge clk);
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        bus.data_addr_ok = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.in_valid = 1'b0; bus.mem_op = 4'd0;
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.data_data_ok = 1'b0;
        chk("rst_resp_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_resp_data", bus.write_data_out, 32'h0);
        chk("rst_resp_req", 32'(bus.data_req), 32'd0);
        chk("rst_resp_stall", 32'(bus.mem_stall), 32'd0);

`ifdef MEM_ADDR_EXC_EN
        // Misaligned word load: no request, exception in one cycle.
        bus.in_valid = 1'b1; bus.mem_op = 4'd5; bus.alu_result = 32'h302; bus.reg_write_in = 1'b1;
        #1 chk("exc_no_stall", 32'(bus.mem_stall), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.mem_op = 4'd0;
        chk("exc_req", 32'(bus.data_req), 32'd0);
        chk("exc_flag", 32'(bus.addr_exc), 32'd1);
        chk("exc_vaddr", bus.bad_vaddr, 32'h302);
        chk("exc_valid", 32'(bus.wb_valid), 32'd1);
        chk("exc_rw", 32'(bus.reg_write_out), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
